// File: rtl/spi_master.sv
// SPI master, mode 0 (SCK idles low, MISO sampled on the rising SCK edge, MOSI changes on the falling edge).
// Every output comes straight from a flop; phase timing uses a down-counter with a terminal-count compare.
//
// state     | meaning
// S_IDLE    | CS high, waiting for i_start
// S_SETUP   | CS low, first MOSI bit settling before the first SCK rise
// S_SCKHIGH | SCK high half period
// S_SCKLOW  | SCK low half period between bits
// S_HOLD    | trailing SCK-low half period, then CS hold with MOSI on the last bit
// S_GAP     | CS high, still busy, before returning to idle

module spi_master #(
  parameter int DATALEN    = 8,
  parameter int HALFPERIOD = 4
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               i_start,
  input  logic [DATALEN-1:0] i_masterDataOut,
  output logic [DATALEN-1:0] o_masterDataIn,
  output logic               o_transferDone,
  output logic               o_busy,
  output logic               o_SPICLK,
  output logic               o_MOSI,
  input  logic               i_MISO,
  output logic               o_CS
);

  localparam int PH_W  = $clog2(2 * HALFPERIOD);
  localparam int BIT_W = $clog2(DATALEN + 1);

  localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(HALFPERIOD - 1);
  localparam logic [PH_W-1:0]  PH_HOLD  = PH_W'(2 * HALFPERIOD - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATALEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SCKHIGH,
    S_SCKLOW,
    S_HOLD,
    S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [BIT_W-1:0]   bits_q, bits_d;
  logic [DATALEN-1:0] tx_q, tx_d;
  logic [DATALEN-1:0] rx_q, rx_d;
  logic [DATALEN-1:0] rxout_q, rxout_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               sclk_q, sclk_d;
  logic               cs_q, cs_d;
  logic               phase_tc;

  assign phase_tc = (phase_q == '0);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bits_d  = bits_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rxout_d = rxout_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    sclk_d  = sclk_q;
    cs_d    = cs_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_SETUP;
          phase_d = PH_HALF;
          bits_d  = '0;
          tx_d    = i_masterDataOut;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end

      S_SETUP, S_SCKLOW: begin
        if (phase_tc) begin
          state_d = S_SCKHIGH;
          phase_d = PH_HALF;
          sclk_d  = 1'b1;
          rx_d    = {rx_q[DATALEN-2:0], i_MISO};
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end

      S_SCKHIGH: begin
        if (phase_tc) begin
          sclk_d = 1'b0;
          bits_d = bits_q + 1'b1;
          if (bits_q == BIT_LAST) begin
            state_d = S_HOLD;
            phase_d = PH_HOLD;
          end else begin
            // MOSI is the TX MSB, so shifting here advances it on the falling SCK edge
            state_d = S_SCKLOW;
            phase_d = PH_HALF;
            tx_d    = {tx_q[DATALEN-2:0], 1'b0};
          end
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end

      S_HOLD: begin
        if (phase_tc) begin
          state_d = S_GAP;
          phase_d = PH_HALF;
          cs_d    = 1'b1;
          rxout_d = rx_q;
          done_d  = 1'b1;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end

      S_GAP: begin
        if (phase_tc) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      bits_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rxout_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bits_q  <= bits_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rxout_q <= rxout_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
    end
  end

  assign o_masterDataIn = rxout_q;
  assign o_transferDone = done_q;
  assign o_busy         = busy_q;
  assign o_SPICLK       = sclk_q;
  assign o_MOSI         = tx_q[DATALEN-1];
  assign o_CS           = cs_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master (DATALEN=5, HALFPERIOD=2): loopback, tied MISO, start filtering,
// back-to-back transfers, asynchronous reset abort and a behavioural mode-0 slave.

module tb_spi_master;

  localparam int DL = 5;
  localparam int HP = 2;

  logic          CLK = 1'b0;
  logic          RSTN;
  logic          i_start;
  logic [DL-1:0] i_masterDataOut;
  logic [DL-1:0] o_masterDataIn;
  logic          o_transferDone;
  logic          o_busy;
  logic          o_SPICLK;
  logic          o_MOSI;
  logic          i_MISO;
  logic          o_CS;

  logic [1:0]    miso_sel;
  logic          slave_miso;

  int checks = 0;
  int errors = 0;

  int rises = 0;
  int dones = 0;
  int cs_viol = 0;
  int short_gaps = 0;
  int cs_run = 0;
  bit sclk_prev = 1'b0;
  bit cs_prev = 1'b0;
  logic [DL-1:0] mosi_seen = '0;

  logic [DL-1:0] slave_sr = '0;
  logic [DL-1:0] slave_rx = '0;
  bit            slave_active = 1'b0;

  int r0, d0, g0;

  always #5 CLK = ~CLK;

  assign i_MISO = (miso_sel == 2'd0) ? o_MOSI :
                  (miso_sel == 2'd1) ? 1'b1   : slave_miso;
  assign slave_miso = slave_sr[DL-1];

  spi_master #(.DATALEN(DL), .HALFPERIOD(HP)) dut (
    .CLK            (CLK),
    .RSTN           (RSTN),
    .i_start        (i_start),
    .i_masterDataOut(i_masterDataOut),
    .o_masterDataIn (o_masterDataIn),
    .o_transferDone (o_transferDone),
    .o_busy         (o_busy),
    .o_SPICLK       (o_SPICLK),
    .o_MOSI         (o_MOSI),
    .i_MISO         (i_MISO),
    .o_CS           (o_CS)
  );

  // bus monitor, sampled mid-cycle
  always @(negedge CLK) begin
    if (o_SPICLK && !sclk_prev) begin
      rises++;
      mosi_seen = {mosi_seen[DL-2:0], o_MOSI};
    end
    if (o_transferDone) dones++;
    if (o_CS && o_SPICLK) cs_viol++;
    if (o_CS) cs_run++;
    else begin
      if (cs_prev && cs_run < 2) short_gaps++;
      cs_run = 0;
    end
    sclk_prev = o_SPICLK;
    cs_prev   = o_CS;
  end

  // mode-0 slave: loads on CS fall, shifts out on SCK fall, samples MOSI on SCK rise
  always @(o_CS or negedge o_SPICLK) begin
    if (o_CS === 1'b1) slave_active = 1'b0;
    else if (o_CS === 1'b0) begin
      if (!slave_active) begin
        slave_sr     = 5'b00101;
        slave_active = 1'b1;
      end else begin
        slave_sr = {slave_sr[DL-2:0], 1'b0};
      end
    end
  end

  always @(posedge o_SPICLK) slave_rx = {slave_rx[DL-2:0], o_MOSI};

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (o_transferDone !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk("done_within_budget", 32'(n < budget), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (o_busy !== 1'b0 && n < budget) begin
      step();
      n++;
    end
    chk("idle_within_budget", 32'(n < budget), 32'd1);
  endtask

  initial begin
    RSTN            = 1'b0;
    i_start         = 1'b0;
    i_masterDataOut = '0;
    miso_sel        = 2'd0;
    repeat (3) step();

    chk("rst_cs",    32'(o_CS), 32'd1);
    chk("rst_sclk",  32'(o_SPICLK), 32'd0);
    chk("rst_mosi",  32'(o_MOSI), 32'd0);
    chk("rst_busy",  32'(o_busy), 32'd0);
    chk("rst_done",  32'(o_transferDone), 32'd0);
    chk("rst_rxout", 32'(o_masterDataIn), 32'd0);

    RSTN = 1'b1;
    repeat (2) step();
    chk("idle_cs", 32'(o_CS), 32'd1);

    // loopback 00101 with exact cycle timing, start asserted after edge k
    i_masterDataOut = 5'b00101;
    i_start = 1'b1;
    r0 = rises; d0 = dones;
    step();                                   // k+1
    i_start = 1'b0;
    chk("t1_cs_low",   32'(o_CS), 32'd0);
    chk("t1_busy",     32'(o_busy), 32'd1);
    chk("t1_mosi_msb", 32'(o_MOSI), 32'd0);
    step();                                   // k+2
    chk("t1_setup_sclk", 32'(o_SPICLK), 32'd0);
    step();                                   // k+3
    chk("t1_first_rise", 32'(o_SPICLK), 32'd1);
    repeat (21) step();                       // k+24
    chk("t1_done_early", 32'(o_transferDone), 32'd0);
    chk("t1_rx_before",  32'(o_masterDataIn), 32'd0);
    step();                                   // k+25
    chk("t1_done",      32'(o_transferDone), 32'd1);
    chk("t1_rxout",     32'(o_masterDataIn), 32'(5'b00101));
    chk("t1_cs_high",   32'(o_CS), 32'd1);
    chk("t1_busy_gap",  32'(o_busy), 32'd1);
    step();                                   // k+26
    chk("t1_done_1cyc", 32'(o_transferDone), 32'd0);
    chk("t1_busy_k26",  32'(o_busy), 32'd1);
    step();                                   // k+27
    chk("t1_busy_low",  32'(o_busy), 32'd0);
    chk("t1_rises",     32'(rises - r0), 32'd5);
    chk("t1_dones",     32'(dones - d0), 32'd1);
    chk("t1_mosi_bits", 32'(mosi_seen), 32'(5'b00101));

    // MISO tied high, all-zero TX word
    miso_sel = 2'd1;
    i_masterDataOut = 5'b00000;
    i_start = 1'b1;
    r0 = rises; d0 = dones;
    step();
    i_start = 1'b0;
    wait_done(40);
    chk("t2_rxout", 32'(o_masterDataIn), 32'(5'b11111));
    wait_idle(10);
    chk("t2_rises",     32'(rises - r0), 32'd5);
    chk("t2_mosi_bits", 32'(mosi_seen), 32'd0);
    chk("t2_dones",     32'(dones - d0), 32'd1);

    // second start and data change while busy are ignored
    miso_sel = 2'd0;
    i_masterDataOut = 5'b11010;
    i_start = 1'b1;
    r0 = rises; d0 = dones;
    step();                                   // k+1
    i_start = 1'b0;
    repeat (9) step();                        // k+10
    i_masterDataOut = 5'b01011;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk("t3_busy", 32'(o_busy), 32'd1);
    wait_idle(40);
    repeat (4) step();
    chk("t3_dones", 32'(dones - d0), 32'd1);
    chk("t3_rxout", 32'(o_masterDataIn), 32'(5'b11010));
    chk("t3_rises", 32'(rises - r0), 32'd5);

    // start held high for 60 cycles: three back-to-back transfers
    i_masterDataOut = 5'b10110;
    r0 = rises; d0 = dones; g0 = short_gaps;
    i_start = 1'b1;
    repeat (60) step();
    i_start = 1'b0;
    wait_idle(40);
    repeat (2) step();
    chk("t4_dones",      32'(dones - d0), 32'd3);
    chk("t4_rises",      32'(rises - r0), 32'd15);
    chk("t4_short_gaps", 32'(short_gaps - g0), 32'd0);
    chk("t4_rxout",      32'(o_masterDataIn), 32'(5'b10110));
    chk("t4_cs_viol",    32'(cs_viol), 32'd0);

    // asynchronous reset mid-transfer at k+12
    i_masterDataOut = 5'b01101;
    i_start = 1'b1;
    d0 = dones;
    step();                                   // k+1
    i_start = 1'b0;
    repeat (11) step();                       // k+12
    chk("t5_pre_sclk", 32'(o_SPICLK), 32'd1);
    chk("t5_pre_cs",   32'(o_CS), 32'd0);
    #2;
    RSTN = 1'b0;
    #1;
    chk("t5_async_cs",    32'(o_CS), 32'd1);
    chk("t5_async_sclk",  32'(o_SPICLK), 32'd0);
    chk("t5_async_busy",  32'(o_busy), 32'd0);
    chk("t5_async_rxout", 32'(o_masterDataIn), 32'd0);
    chk("t5_async_mosi",  32'(o_MOSI), 32'd0);
    repeat (2) step();
    RSTN = 1'b1;
    step();
    chk("t5_no_done", 32'(dones - d0), 32'd0);
    i_start = 1'b1;
    r0 = rises; d0 = dones;
    step();
    i_start = 1'b0;
    wait_done(40);
    chk("t5_rxout", 32'(o_masterDataIn), 32'(5'b01101));
    wait_idle(10);
    chk("t5_rises", 32'(rises - r0), 32'd5);
    chk("t5_dones", 32'(dones - d0), 32'd1);

    // exchange with a mode-0 slave holding 00101
    miso_sel = 2'd2;
    i_masterDataOut = 5'b10010;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    wait_done(40);
    chk("t6_master_rx", 32'(o_masterDataIn), 32'(5'b00101));
    chk("t6_slave_rx",  32'(slave_rx), 32'(5'b10010));
    wait_idle(10);
    chk("t6_cs_viol",   32'(cs_viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
